// File: rtl/asteroids_pkg.sv
// Shared types and helpers for the torpedo fire-control path.
package asteroids_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LAUNCH   = 3'd1,
      COOLDOWN = 3'd2,
      WAIT_REL = 3'd3
   } launch_state_t;

   // Width of the cooldown frame counter; never narrower than one bit.
   function automatic int unsigned frame_tick_w(input int unsigned frames);
      int unsigned w;
      w = $clog2(frames + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fire_debounce.sv
// Frame-window debounce: fire must be high on every sampled cycle of a frame to count.
module fire_debounce (
   input  logic clk,
   input  logic resetN,
   input  logic vsync,
   input  logic fire,
   output logic fire_deb,
   output logic fire_deb_nxt
);

   logic window;
   logic phase;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         window   <= 1'b0;
         phase    <= 1'b0;
         fire_deb <= 1'b0;
      end else begin
         phase <= ~phase;
         if (vsync) begin
            window   <= 1'b1;
            fire_deb <= window;
         end else if (phase) begin
            window <= window & fire;
         end
      end
   end

   assign fire_deb_nxt = window;

endmodule

// File: rtl/torpedo_launcher.sv
// Torpedo fire control: debounced fire, cooldown, round-robin slot launch per frame.
// Optional TORPEDO_LAUNCHER_AUTOFIRE_EN: relaunch at cooldown exit while fire is held.
module torpedo_launcher
   import asteroids_pkg::*;
#(
   parameter int unsigned NUM_SLOTS       = 4,
   parameter int unsigned COOLDOWN_FRAMES = 3,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 vsync,
   input  logic                 fire,
   input  logic [NUM_SLOTS-1:0] slot_busy,
   input  logic [NUM_SLOTS-1:0] slot_dead,
   output logic [NUM_SLOTS-1:0] launch,
   output logic                 launch_any,
   output logic                 fire_deb,
   output logic                 no_slot,
   output logic [CNT_W-1:0]     shots_fired,
   output logic [2:0]           state
);

   localparam int unsigned IDX_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned FRAME_TICK_W = frame_tick_w(COOLDOWN_FRAMES);
   localparam logic [FRAME_TICK_W-1:0] CD_LOAD =
      (COOLDOWN_FRAMES == 0) ? '0 : FRAME_TICK_W'(COOLDOWN_FRAMES - 1);

   // Returns {found, index} of the first free slot at or after ptr, wrapping.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SLOTS-1:0] free,
                                              input logic [IDX_W-1:0]     ptr);
      logic [IDX_W:0] r;
      int unsigned    idx;
      r = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
         if (!r[IDX_W] && (((free >> idx) & NUM_SLOTS'(1)) != '0))
            r = {1'b1, IDX_W'(idx)};
      end
      return r;
   endfunction

   launch_state_t           st;
   logic [IDX_W-1:0]        rr_ptr;
   logic [FRAME_TICK_W-1:0] cd_cnt;
   logic                    fire_deb_nxt;
   logic [NUM_SLOTS-1:0]    slot_free;
   logic [IDX_W:0]          pick;
   logic                    pick_ok;
   logic [IDX_W-1:0]        pick_idx;
   logic [IDX_W-1:0]        pick_next;
   logic [NUM_SLOTS-1:0]    pick_onehot;

   fire_debounce u_fire_debounce (
      .clk          (clk),
      .resetN       (resetN),
      .vsync        (vsync),
      .fire         (fire),
      .fire_deb     (fire_deb),
      .fire_deb_nxt (fire_deb_nxt)
   );

   // A dead pulse frees the slot even while its busy flag is still up.
   assign slot_free   = ~slot_busy | slot_dead;
   assign pick        = rr_pick(slot_free, rr_ptr);
   assign pick_ok     = pick[IDX_W];
   assign pick_idx    = pick[IDX_W-1:0];
   assign pick_next   = (pick_idx == IDX_W'(NUM_SLOTS - 1)) ? '0 : pick_idx + 1'b1;
   assign pick_onehot = NUM_SLOTS'(1) << pick_idx;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         st          <= IDLE;
         launch      <= '0;
         no_slot     <= 1'b0;
         shots_fired <= '0;
         rr_ptr      <= '0;
         cd_cnt      <= '0;
      end else if (vsync) begin
         launch  <= '0;
         no_slot <= 1'b0;
         unique case (st)
            IDLE: begin
               if (fire_deb_nxt) begin
                  if (pick_ok) begin
                     st          <= LAUNCH;
                     launch      <= pick_onehot;
                     rr_ptr      <= pick_next;
                     shots_fired <= shots_fired + 1'b1;
                  end else begin
                     no_slot <= 1'b1;
                  end
               end
            end
            LAUNCH: begin
               cd_cnt <= CD_LOAD;
               st     <= (COOLDOWN_FRAMES == 0) ? WAIT_REL : COOLDOWN;
            end
            COOLDOWN: begin
               if (cd_cnt != '0) begin
                  cd_cnt <= cd_cnt - 1'b1;
               end else begin
`ifdef TORPEDO_LAUNCHER_AUTOFIRE_EN
                  if (fire_deb_nxt && pick_ok) begin
                     st          <= LAUNCH;
                     launch      <= pick_onehot;
                     rr_ptr      <= pick_next;
                     shots_fired <= shots_fired + 1'b1;
                  end else if (fire_deb_nxt) begin
                     st      <= IDLE;
                     no_slot <= 1'b1;
                  end else begin
                     st <= WAIT_REL;
                  end
`else
                  st <= WAIT_REL;
`endif
               end
            end
            WAIT_REL: begin
               if (!fire_deb_nxt) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign launch_any = |launch;
   assign state      = st;

endmodule
